// File: rtl/div4_pkg.sv
// ============================================================================
// Module      : div4_pkg
// Description : Shared width, iteration count and FSM state constants for the
//               4-bit sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div4_pkg;

    localparam int W    = 4;
    localparam int ITER = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage : div4_pkg

`default_nettype wire

// File: rtl/div4_seq_if.sv
// ============================================================================
// Module      : div4_seq_if
// Description : Request/result bundle between a divider client and div4_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div4_seq_if;
    import div4_pkg::*;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         busy;
    logic         done;
    logic         div_zero;

    modport master (
        output start, a, b,
        input  q, r, busy, done, div_zero
    );

    modport slave (
        input  start, a, b,
        output q, r, busy, done, div_zero
    );

endinterface : div4_seq_if

`default_nettype wire

// File: rtl/sub4.sv
// ============================================================================
// Module      : sub4
// Description : 4-bit unsigned subtractor; s[4] is the borrow (a < b).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub4 (
    input  wire logic [3:0] a,
    input  wire logic [3:0] b,
    output wire logic [4:0] s
);

    assign s = {1'b0, a} - {1'b0, b};

endmodule : sub4

`default_nettype wire

// File: rtl/div4_seq.sv
// ============================================================================
// Module      : div4_seq
// Description : Sequential 4-bit unsigned restoring divider, one quotient bit
//               per clock, built around a single sub4 instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div4_seq
    import div4_pkg::*;
#(
    parameter logic [W-1:0] DZ_QUOT = 4'hF
) (
    input  wire logic   ck,
    input  wire logic   rst,
    div4_seq_if.slave   bus
);

    logic [1:0]   r_state;
    logic [W-1:0] r_rem;
    logic [W-1:0] r_quo;
    logic [W-1:0] r_dvs;
    logic [1:0]   r_cnt;
    logic [W-1:0] r_q;
    logic [W-1:0] r_r;
    logic         r_div_zero;

    logic [W-1:0] w_partial;
    logic [W:0]   w_diff;
    logic [W-1:0] w_rem_nxt;
    logic [W-1:0] w_quo_nxt;

    // Remainder never exceeds 2^k after step k, so the shifted partial fits in 4 bits.
    assign w_partial = {r_rem[W-2:0], r_quo[W-1]};

    sub4 u_sub4 (
        .a (w_partial),
        .b (r_dvs),
        .s (w_diff)
    );

    assign w_rem_nxt = w_diff[W] ? w_partial : w_diff[W-1:0];
    assign w_quo_nxt = {r_quo[W-2:0], ~w_diff[W]};

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_cnt      <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.b != '0) begin
                            r_dvs      <= bus.b;
                            r_quo      <= bus.a;
                            r_rem      <= '0;
                            r_cnt      <= 2'(ITER - 1);
                            r_div_zero <= 1'b0;
                            r_state    <= S_RUN;
                        end else begin
                            r_q        <= DZ_QUOT;
                            r_r        <= bus.a;
                            r_div_zero <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    if (r_cnt == 2'd0) begin
                        r_q     <= w_quo_nxt;
                        r_r     <= w_rem_nxt;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.q        = r_q;
    assign bus.r        = r_r;
    assign bus.div_zero = r_div_zero;
    assign bus.busy     = (r_state == S_RUN);
    assign bus.done     = (r_state == S_DONE);

endmodule : div4_seq

`default_nettype wire

// File: tb/tb_div4_seq.sv
// ============================================================================
// Module      : tb_div4_seq
// Description : Self-checking bench for div4_seq against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div4_seq;

    logic ck;
    logic rst;
    int   n_vec;
    int   n_err;

    div4_seq_if bus ();

    div4_seq #(.DZ_QUOT(4'hF)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus.slave)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    logic [3:0] last_q, last_r;
    logic       last_dz;

    // Issues one operation and checks latency, busy length, held outputs and result.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_);
        int         busy_cyc;
        int         cyc;
        logic [3:0] eq, er;
        logic       edz;
        if (tb_ == 4'd0) begin
            eq = 4'hF; er = ta; edz = 1'b1;
        end else begin
            eq = ta / tb_; er = ta % tb_; edz = 1'b0;
        end
        bus.a = ta; bus.b = tb_; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom;
        busy_cyc = 0;
        cyc = 0;
        while (!bus.done && cyc < 12) begin
            if (bus.busy) begin
                busy_cyc++;
                if (busy_cyc == 2) begin
                    check("hold_q", bus.q, last_q);
                    check("hold_r", bus.r, last_r);
                end
            end
            tick();
            cyc++;
        end
        check("done_seen", bus.done, 1'b1);
        check("busy_len", busy_cyc, (tb_ == 4'd0) ? 0 : 4);
        check("q", bus.q, eq);
        check("r", bus.r, er);
        check("div_zero", bus.div_zero, edz);
        last_q = eq; last_r = er; last_dz = edz;
        tick();
        check("done_pulse", bus.done, 1'b0);
    endtask

    initial begin
        int errs_before;
        n_vec = 0; n_err = 0;
        last_q = '0; last_r = '0; last_dz = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_q", bus.q, 4'd0);
            check("rst_r", bus.r, 4'd0);
            check("rst_busy", bus.busy, 1'b0);
            check("rst_done", bus.done, 1'b0);
            check("rst_dz", bus.div_zero, 1'b0);
            tick();
        end

        run_op(4'd13, 4'd3);
        run_op(4'd15, 4'd1);
        run_op(4'd14, 4'd15);
        run_op(4'd0,  4'd7);
        run_op(4'd15, 4'd15);
        run_op(4'd9,  4'd0);
        run_op(4'd8,  4'd2);

        // Start pulse during RUN must be ignored.
        bus.a = 4'd13; bus.b = 4'd3; bus.start = 1'b1;
        tick();
        bus.a = 4'd1; bus.b = 4'd1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10 && !bus.done; i++) tick();
        check("ign_q", bus.q, 4'd4);
        check("ign_r", bus.r, 4'd1);
        // Start during DONE is ignored too.
        bus.a = 4'd6; bus.b = 4'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("done_start_busy", bus.busy, 1'b0);
        check("done_start_done", bus.done, 1'b0);
        check("done_start_dz", bus.div_zero, 1'b0);
        tick();
        check("done_start_idle", bus.done, 1'b0);

        // Reset in the second RUN cycle aborts the operation.
        bus.a = 4'd13; bus.b = 4'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("abort_busy_pre", bus.busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("abort_done", bus.done, 1'b0);
            check("abort_busy", bus.busy, 1'b0);
            tick();
        end
        check("abort_q", bus.q, 4'd0);
        check("abort_r", bus.r, 4'd0);
        last_q = '0; last_r = '0;

        errs_before = n_err;
        for (int v = 0; v < 256; v++) begin
            run_op(v[3:0], v[7:4]);
            if (n_err != errs_before) break;
        end
        if (n_err == errs_before) $display("OK");

        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom), 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_div4_seq

`default_nettype wire

// File: doc/div4_seq.md
Name: div4_seq

Overview:
- Sequential 4-bit unsigned restoring divider. It computes q = a / b and r = a % b, one quotient bit per clock.
- It sits directly downstream of sub4: it instantiates sub4 and consumes its 5-bit difference every iteration, using s[4] as the borrow/sign bit.
- First multi-cycle arithmetic block in the 4-bit datapath family.

Parameters:
- DZ_QUOT, 4'hF, quotient value reported on divide-by-zero.

Ports:
- ck  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  4  dividend; sampled with start.
- b  input  4  divisor; sampled with start.
- q  output  4  quotient; registered, holds last result.
- r  output  4  remainder; registered, holds last result.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when q/r have just been updated.
- div_zero  output  1  status of the last completed operation; set if b was 0.

Behaviour:
- Reset: one clock was decided, and reset is synchronous and active-high, on port rst.
  - rst=1 at a rising edge forces state IDLE and q=0, r=0, busy=0, done=0, div_zero=0.
  - Internal rem, quo, dvs and cnt are also zeroed.
  - rst has priority over everything, including mid-operation. An aborted operation produces no done and leaves q/r at 0.
- States: IDLE, RUN, DONE. Encoding is 2 bits, from the package.
- IDLE:
  - start=1 and b!=0: dvs<=b, quo<=a, rem<=0, cnt<=3, div_zero<=0, next RUN.
  - start=1 and b==0: q<=DZ_QUOT, r<=a, div_zero<=1, next DONE. There is no iteration.
  - start=0: stay in IDLE.
- RUN, one iteration per edge:
  - partial = {rem[2:0], quo[3]}, 4 bits. This cannot overflow: after step k, rem < 2^k.
  - sub4 inputs: a=partial, b=dvs. Output is diff[4:0].
  - If diff[4]==0: rem<=diff[3:0], quo<={quo[2:0],1}.
  - If diff[4]==1: rem<=partial, quo<={quo[2:0],0}.
  - cnt==0: the final iteration also writes q<=new quo and r<=new rem, next DONE. Otherwise cnt<=cnt-1.
- DONE: done=1 for exactly this cycle, then next IDLE unconditionally.
- Output decode:
  - busy = (state==RUN).
  - done = (state==DONE).
  - Both are decoded from registered state, so they are glitch-free.
- Latency:
  - start sampled at edge E0, iterations at E1..E4, q/r valid and done=1 between E4 and E5. That is 4 cycles from start to done.
  - Divide-by-zero: done=1 between E0 and E1, i.e. 1 cycle.
  - Throughput: one operation per 6 edges. start asserted during the DONE cycle is ignored; start is accepted again from the following IDLE.
- start while busy or done: ignored. a/b changes during RUN have no effect because operands are latched.
- q/r/div_zero hold their values until the next completed operation or rst. They do not change during RUN.
- sub4 is used purely combinationally with a single instance. No other subtractor exists in the block.

Decomposition:
- Package div4_pkg:
  - W=4 (fixed by sub4).
  - State constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - ITER=4.
- Sub-module: sub4 (existing, unmodified), instantiated once as the iteration subtractor.
- Control FSM and datapath stay in div4_seq. No further split.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0. Expect q=0, r=0, busy=0, done=0, div_zero=0, all held.
- Basic: a=13, b=3, start 1 cycle. Expect busy=1 for 4 cycles, then done pulse with q=4, r=1, div_zero=0.
- Edges:
  - a=15, b=1: q=15, r=0.
  - a=14, b=15: q=0, r=14.
  - a=0, b=7: q=0, r=0.
  - a=15, b=15: q=1, r=0.
- Divide-by-zero: a=9, b=0. Expect done on the next cycle, q=4'hF, r=9, div_zero=1, busy never high. A following a=8, b=2 clears div_zero and gives q=4, r=0.
- Disturbance:
  - Start a=13, b=3. Pulse start with a=1, b=1 during RUN: it is ignored and the result is still q=4, r=1.
  - Separately, assert rst at the 2nd RUN cycle: expect IDLE, no done, q=r=0.
- Exhaustive sweep: {b,a} incremented over all 256 values. On each done, check q==a/b and r==a%b (b!=0), or DZ_QUOT/a (b==0). Print "OK" after a=b=15 and finish on the first mismatch.
